// File: rtl/rx_pkt_word_packer.sv
// rx_pkt_word_packer
// Packs the receiver's per-packet byte stream into 64-bit words for the rx DMA:
// one header word, the payload words, then one trailer word with FCS/error status.
// An output FIFO with valid/ready decouples decoder timing from the DMA.
//
// Ports:
//   s00_axi_aclk / s00_axi_aresetn       clock, asynchronous active-low reset
//   pkt_header_valid_strobe, pkt_header_valid, pkt_rate, pkt_len   header decode result
//   byte_out_strobe, byte_out            payload byte stream
//   fcs_out_strobe, fcs_ok               FCS check result
//   word_out, word_out_valid, word_out_last, word_out_ready        FIFO head handshake
//   pkt_drop_cnt                         packets lost to a full FIFO (saturating)
//   busy                                 FSM not idle
module rx_pkt_word_packer #(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned FCS_TIMEOUT = 4095
) (
  input  logic        s00_axi_aclk,
  input  logic        s00_axi_aresetn,
  input  logic        pkt_header_valid_strobe,
  input  logic        pkt_header_valid,
  input  logic [7:0]  pkt_rate,
  input  logic [15:0] pkt_len,
  input  logic        byte_out_strobe,
  input  logic [7:0]  byte_out,
  input  logic        fcs_out_strobe,
  input  logic        fcs_ok,
  output logic [63:0] word_out,
  output logic        word_out_valid,
  output logic        word_out_last,
  input  logic        word_out_ready,
  output logic [15:0] pkt_drop_cnt,
  output logic        busy
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned TW = $clog2(FCS_TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StPayload, StWaitFcs, StTrailer} state_e;

  state_e        state_q;
  logic [31:0]   timestamp_q;
  logic [15:0]   pkt_len_q;
  logic [15:0]   byte_cnt_q;
  logic [63:0]   word_q;
  logic [TW-1:0] wait_cnt_q;
  logic          fcs_seen_q, fcs_ok_q, timeout_q, abort_q, overflow_q;
  logic [15:0]   drop_cnt_q;

  logic [63:0]   mem_data_q [FIFO_DEPTH];
  logic          mem_last_q [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_q, rd_ptr_q;

  logic          fifo_empty, fifo_full, pop, can_push;
  logic          push, push_last;
  logic [63:0]   push_data;
  logic          hdr_ok, last_byte;
  logic [2:0]    lane;
  logic [63:0]   cur_word, header_word, trailer_word;

  // Extra pointer MSB distinguishes full from empty.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop        = !fifo_empty && word_out_ready;
  // A same-cycle pop frees the slot for the push.
  assign can_push   = !fifo_full || pop;

  assign word_out       = mem_data_q[rd_ptr_q[AW-1:0]];
  assign word_out_last  = mem_last_q[rd_ptr_q[AW-1:0]];
  assign word_out_valid = !fifo_empty;
  assign pkt_drop_cnt   = drop_cnt_q;
  assign busy           = (state_q != StIdle);

  assign hdr_ok       = pkt_header_valid_strobe && pkt_header_valid;
  assign lane         = byte_cnt_q[2:0];
  // word_q holds zeros above the current lane, so OR-ing gives zero padding.
  assign cur_word     = word_q | ({56'd0, byte_out} << {lane, 3'b000});
  assign last_byte    = ((byte_cnt_q + 16'd1) == pkt_len_q);
  assign header_word  = {timestamp_q, 8'hA5, pkt_rate, pkt_len};
  assign trailer_word = {byte_cnt_q, 44'd0, timeout_q, abort_q, overflow_q, fcs_ok_q};

  always_comb begin
    push      = 1'b0;
    push_data = cur_word;
    push_last = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (hdr_ok && can_push) begin
          push      = 1'b1;
          push_data = header_word;
        end
      end
      StPayload: begin
        // An abort in the same cycle discards the word being completed.
        if (byte_out_strobe && !hdr_ok && ((lane == 3'd7) || last_byte) && can_push) begin
          push = 1'b1;
        end
      end
      StTrailer: begin
        if (can_push) begin
          push      = 1'b1;
          push_data = trailer_word;
          push_last = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      state_q     <= StIdle;
      timestamp_q <= '0;
      pkt_len_q   <= '0;
      byte_cnt_q  <= '0;
      word_q      <= '0;
      wait_cnt_q  <= '0;
      fcs_seen_q  <= 1'b0;
      fcs_ok_q    <= 1'b0;
      timeout_q   <= 1'b0;
      abort_q     <= 1'b0;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      timestamp_q <= timestamp_q + 32'd1;
      unique case (state_q)
        StIdle: begin
          if (hdr_ok) begin
            if (can_push) begin
              pkt_len_q  <= pkt_len;
              byte_cnt_q <= '0;
              word_q     <= '0;
              wait_cnt_q <= '0;
              fcs_seen_q <= 1'b0;
              fcs_ok_q   <= 1'b0;
              timeout_q  <= 1'b0;
              abort_q    <= 1'b0;
              overflow_q <= 1'b0;
              state_q    <= (pkt_len == 16'd0) ? StWaitFcs : StPayload;
            end else if (drop_cnt_q != 16'hFFFF) begin
              drop_cnt_q <= drop_cnt_q + 16'd1;
            end
          end
        end
        StPayload: begin
          // The byte arriving with an abort still counts as received.
          if (byte_out_strobe) byte_cnt_q <= byte_cnt_q + 16'd1;
          if (hdr_ok) begin
            abort_q <= 1'b1;
            word_q  <= '0;
            state_q <= StTrailer;
          end else if (byte_out_strobe) begin
            if ((lane == 3'd7) || last_byte) begin
              word_q <= '0;
              if (!can_push) overflow_q <= 1'b1;
            end else begin
              word_q <= cur_word;
            end
            if (last_byte) begin
              state_q <= StWaitFcs;
              if (fcs_out_strobe) begin
                fcs_seen_q <= 1'b1;
                fcs_ok_q   <= fcs_ok;
              end
            end
          end
        end
        StWaitFcs: begin
          if (hdr_ok) begin
            abort_q <= 1'b1;
            state_q <= StTrailer;
          end else if (fcs_seen_q) begin
            state_q <= StTrailer;
          end else if (fcs_out_strobe) begin
            fcs_ok_q <= fcs_ok;
            state_q  <= StTrailer;
          end else if (wait_cnt_q == TW'(FCS_TIMEOUT - 1)) begin
            timeout_q <= 1'b1;
            fcs_ok_q  <= 1'b0;
            state_q   <= StTrailer;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        StTrailer: begin
          if (can_push) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_data_q[i] <= '0;
        mem_last_q[i] <= 1'b0;
      end
    end else begin
      if (push) begin
        mem_data_q[wr_ptr_q[AW-1:0]] <= push_data;
        mem_last_q[wr_ptr_q[AW-1:0]] <= push_last;
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

endmodule
